mem_arbiter: RTL

Single-port RAM arbiter and byte sequencer between the instruction-fetch unit and the load/store buffer. Grants the byte-wide memory bus to one requester at a time, splits 1/2/4-byte accesses into per-byte RAM cycles and reassembles read data little-endian. Stalls I/O writes on `io_buffer_full` and aborts speculative reads on `clear_all`. Sits between the core (ifetch, LSB, ROB flush) and the external RAM/IO port.

---
 rtl/mem_arbiter.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Byte-wide RAM arbiter between instruction fetch and the load/store buffer.
// Splits 1/2/4-byte accesses into per-byte cycles and reassembles reads little-endian.
module mem_arbiter #(
    parameter logic [1:0] IO_HI = 2'b11
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,

    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,

    input  logic        io_buffer_full,
    input  logic        clear_all,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,

    input  logic        lsb_go,
    input  logic        lsb_ls,
    input  logic [2:0]  lsb_width,
    input  logic [31:0] lsb_addr,
    input  logic [31:0] lsb_wdata,
    output logic        lsb_received,
    output logic        lsb_has_result,
    output logic [31:0] lsb_rdata
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = 8;
    localparam int unsigned CW = 3;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_LS = 1'b1;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] n_q, n_d;
    logic          req_q, req_d;
    logic          last_grant_q, last_grant_d;
    logic [AW-1:0] base_q, base_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rbuf_q, rbuf_d;

    logic [AW-1:0] mem_a_q, mem_a_d;
    logic [BW-1:0] mem_dout_q, mem_dout_d;
    logic          mem_wr_q, mem_wr_d;
    logic          if_done_q, if_done_d;
    logic [DW-1:0] if_data_q, if_data_d;
    logic          lsb_received_q, lsb_received_d;
    logic          lsb_has_result_q, lsb_has_result_d;
    logic [DW-1:0] lsb_rdata_q, lsb_rdata_d;

    logic [CW-1:0] n_lsb;
    logic          lsb_req;
    logic          grant_ls;
    logic          grant_if;
    logic          io_stall;
    logic          io_stall_accept;
    logic [1:0]    rd_idx;
    logic [DW-1:0] rbuf_ins;
    logic [BW-1:0] wbyte;

    // Unsupported widths fall back to a single byte.
    always_comb begin
        case (lsb_width)
            3'd1:    n_lsb = 3'd1;
            3'd2:    n_lsb = 3'd2;
            3'd4:    n_lsb = 3'd4;
            default: n_lsb = 3'd1;
        endcase
    end

    // The LSB drops lsb_go one edge after the acceptance pulse; ignore it meanwhile.
    assign lsb_req  = lsb_go & ~lsb_received_q;
    assign grant_ls = (state_q == S_IDLE) & ~clear_all & lsb_req
                    & (~if_req | (last_grant_q == REQ_IF));
    assign grant_if = (state_q == S_IDLE) & ~clear_all & if_req & ~grant_ls;

    assign io_stall        = (base_q[17:16] == IO_HI) & io_buffer_full;
    assign io_stall_accept = (lsb_addr[17:16] == IO_HI) & io_buffer_full;

    // Byte returned now belongs to the address issued two edges earlier.
    assign rd_idx   = 2'(cnt_q - 3'd2);
    assign rbuf_ins = rbuf_q | (32'(mem_din) << {rd_idx, 3'b000});
    assign wbyte    = 8'(wdata_q >> {cnt_q[1:0], 3'b000});

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        n_d              = n_q;
        req_d            = req_q;
        last_grant_d     = last_grant_q;
        base_d           = base_q;
        wdata_d          = wdata_q;
        rbuf_d           = rbuf_q;
        mem_a_d          = mem_a_q;
        mem_dout_d       = mem_dout_q;
        mem_wr_d         = 1'b0;
        if_done_d        = 1'b0;
        if_data_d        = if_data_q;
        lsb_received_d   = 1'b0;
        lsb_has_result_d = 1'b0;
        lsb_rdata_d      = lsb_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (grant_ls) begin
                    req_d          = REQ_LS;
                    last_grant_d   = REQ_LS;
                    base_d         = lsb_addr;
                    n_d            = n_lsb;
                    wdata_d        = lsb_wdata;
                    rbuf_d         = '0;
                    mem_a_d        = lsb_addr;
                    lsb_received_d = 1'b1;
                    if (lsb_ls) begin
                        if (io_stall_accept) begin
                            cnt_d   = 3'd0;
                            state_d = S_WR;
                        end else begin
                            mem_wr_d   = 1'b1;
                            mem_dout_d = lsb_wdata[7:0];
                            cnt_d      = 3'd1;
                            state_d    = (n_lsb == 3'd1) ? S_IDLE : S_WR;
                        end
                    end else begin
                        cnt_d   = 3'd1;
                        state_d = S_RD;
                    end
                end else if (grant_if) begin
                    req_d        = REQ_IF;
                    last_grant_d = REQ_IF;
                    base_d       = if_addr;
                    n_d          = 3'd4;
                    rbuf_d       = '0;
                    mem_a_d      = if_addr;
                    cnt_d        = 3'd1;
                    state_d      = S_RD;
                end
            end

            S_RD: begin
                if (clear_all) begin
                    state_d = S_IDLE;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q < n_q) begin
                        mem_a_d = base_q + 32'(cnt_q);
                    end
                    if (cnt_q >= 3'd2) begin
                        rbuf_d = rbuf_ins;
                    end
                    if (cnt_q == n_q + 3'd1) begin
                        state_d = S_IDLE;
                        cnt_d   = 3'd0;
                        if (req_q == REQ_IF) begin
                            if_done_d = 1'b1;
                            if_data_d = rbuf_ins;
                        end else begin
                            lsb_has_result_d = 1'b1;
                            lsb_rdata_d      = rbuf_ins;
                        end
                    end
                end
            end

            S_WR: begin
                // A committed store ignores clear_all; only a full I/O buffer holds it.
                if (!io_stall) begin
                    mem_a_d    = base_q + 32'(cnt_q);
                    mem_dout_d = wbyte;
                    mem_wr_d   = 1'b1;
                    cnt_d      = cnt_q + 3'd1;
                    if (cnt_q + 3'd1 == n_q) begin
                        state_d = S_IDLE;
                        cnt_d   = 3'd0;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q          <= S_IDLE;
            cnt_q            <= '0;
            n_q              <= '0;
            req_q            <= REQ_IF;
            last_grant_q     <= REQ_IF;
            base_q           <= '0;
            wdata_q          <= '0;
            rbuf_q           <= '0;
            mem_a_q          <= '0;
            mem_dout_q       <= '0;
            mem_wr_q         <= 1'b0;
            if_done_q        <= 1'b0;
            if_data_q        <= '0;
            lsb_received_q   <= 1'b0;
            lsb_has_result_q <= 1'b0;
            lsb_rdata_q      <= '0;
        end else if (rdy_in) begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            n_q              <= n_d;
            req_q            <= req_d;
            last_grant_q     <= last_grant_d;
            base_q           <= base_d;
            wdata_q          <= wdata_d;
            rbuf_q           <= rbuf_d;
            mem_a_q          <= mem_a_d;
            mem_dout_q       <= mem_dout_d;
            mem_wr_q         <= mem_wr_d;
            if_done_q        <= if_done_d;
            if_data_q        <= if_data_d;
            lsb_received_q   <= lsb_received_d;
            lsb_has_result_q <= lsb_has_result_d;
            lsb_rdata_q      <= lsb_rdata_d;
        end
    end

    // The RAM pauses on the same rdy_in, so a held write strobe must not leak through.
    assign mem_wr         = mem_wr_q & rdy_in;
    assign mem_a          = mem_a_q;
    assign mem_dout       = mem_dout_q;
    assign if_done        = if_done_q;
    assign if_data        = if_data_q;
    assign lsb_received   = lsb_received_q;
    assign lsb_has_result = lsb_has_result_q;
    assign lsb_rdata      = lsb_rdata_q;

endmodule
